// File: rtl/motor_array_pwm.sv
// N-channel DC motor controller: per-channel run/dead/stop FSM with a shared PWM counter.
// Optional soft-start ramp on the effective duty is compiled in with `define MOTOR_RAMP_EN.
module motor_array_pwm #(
    parameter int CH        = 2,
    parameter int PWM_BITS  = 8,
    parameter int DEAD_TIME = 124999999
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CH-1:0]          BTN,
    input  logic [CH-1:0]          SW,
    input  logic                   PWM_EN,
    input  logic [CH*PWM_BITS-1:0] DUTY,
    output logic [CH-1:0]          MOTOR_EN,
    output logic [CH-1:0]          MOTOR_DIR,
    output logic [CH-1:0]          DEAD_ACTIVE
);

    localparam int DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_TIME);
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_wrap;

    assign w_wrap = (r_pwm_cnt == PWM_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t              r_state;
            state_t              w_state_next;
            logic [PWM_BITS-1:0] r_shadow;
            logic [PWM_BITS-1:0] w_shadow_next;
            logic [PWM_BITS-1:0] w_eff_duty;
            logic [DW-1:0]       r_dead_cnt;
            logic                r_en;
            logic                r_dir;
            logic                r_dead;
            logic                w_exit;
            logic                w_pwm_on;

            // Duty only changes on a period boundary so a period is never split.
            assign w_shadow_next = w_wrap ? DUTY[gi*PWM_BITS +: PWM_BITS] : r_shadow;
            assign w_exit        = ~BTN[gi] | (SW[gi] != r_dir);
            assign w_pwm_on      = PWM_EN ? (r_pwm_cnt < w_eff_duty) : 1'b1;

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    ST_STOP: if (BTN[gi]) w_state_next = ST_RUN;
                    ST_RUN:  if (w_exit) w_state_next = ST_DEAD;
                    ST_DEAD: if (r_dead_cnt == DEAD_LAST) w_state_next = ST_STOP;
                    default: w_state_next = ST_STOP;
                endcase
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_state <= ST_STOP;
                end else begin
                    r_state <= w_state_next;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_shadow   <= '0;
                    r_dead_cnt <= '0;
                    r_en       <= 1'b0;
                    r_dir      <= 1'b0;
                    r_dead     <= 1'b0;
                end else begin
                    r_shadow <= w_shadow_next;
                    if (r_state == ST_RUN && w_state_next == ST_DEAD) begin
                        r_dead_cnt <= '0;
                    end else if (r_state == ST_DEAD && r_dead_cnt != DEAD_LAST) begin
                        r_dead_cnt <= r_dead_cnt + 1'b1;
                    end
                    r_en   <= (r_state == ST_RUN && w_state_next == ST_RUN) ? w_pwm_on : 1'b0;
                    // Direction follows the switch only while stopped, so it never moves under an enabled bridge.
                    if (r_state == ST_STOP) begin
                        r_dir <= SW[gi];
                    end
                    r_dead <= (w_state_next == ST_DEAD);
                end
            end

`ifdef MOTOR_RAMP_EN
            logic [PWM_BITS-1:0] r_eff;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_eff <= '0;
                end else if (r_state == ST_STOP && w_state_next == ST_RUN) begin
                    r_eff <= '0;
                end else if (w_shadow_next < r_eff) begin
                    r_eff <= w_shadow_next;
                end else if (w_wrap && r_eff < w_shadow_next) begin
                    r_eff <= r_eff + 1'b1;
                end
            end

            assign w_eff_duty = r_eff;
`else
            assign w_eff_duty = r_shadow;
`endif

            assign MOTOR_EN[gi]    = r_en;
            assign MOTOR_DIR[gi]   = r_dir;
            assign DEAD_ACTIVE[gi] = r_dead;
        end
    endgenerate

endmodule

// File: tb/tb_motor_array_pwm.sv
// Directed, table-driven bench for motor_array_pwm (CH=2, PWM_BITS=4, DEAD_TIME=9).
module tb_motor_array_pwm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] BTN;
    logic [1:0] SW;
    logic       PWM_EN;
    logic [7:0] DUTY;
    logic [1:0] MOTOR_EN;
    logic [1:0] MOTOR_DIR;
    logic [1:0] DEAD_ACTIVE;

    int n_checks = 0;
    int n_err    = 0;
    int glitches = 0;

    motor_array_pwm #(
        .CH(2),
        .PWM_BITS(4),
        .DEAD_TIME(9)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .BTN(BTN),
        .SW(SW),
        .PWM_EN(PWM_EN),
        .DUTY(DUTY),
        .MOTOR_EN(MOTOR_EN),
        .MOTOR_DIR(MOTOR_DIR),
        .DEAD_ACTIVE(DEAD_ACTIVE)
    );

    always #5 CLK = ~CLK;

    // Reference copy of the free-running PWM counter, used only to align measurement windows.
    logic [3:0] m_cnt;
    logic       rst_q;
    always @(posedge CLK) begin
        if (RST) m_cnt <= 4'd0;
        else     m_cnt <= m_cnt + 4'd1;
        rst_q <= RST;
    end

    // Direction must hold whenever the enable was high in the previous cycle.
    logic [1:0] prev_en, prev_dir;
    always @(negedge CLK) begin
        if (rst_q !== 1'b1) begin
            for (int c = 0; c < 2; c++)
                if (prev_en[c] === 1'b1 && MOTOR_DIR[c] !== prev_dir[c]) glitches++;
        end
        prev_en  = MOTOR_EN;
        prev_dir = MOTOR_DIR;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            if (m_cnt == v) found = 1'b1;
        end
        check("wait_cnt_timeout", {31'd0, found}, 32'd1);
    endtask

    // Called on the sample where m_cnt==1: 16 samples cover pwm_cnt 0..15 of one period.
    task automatic measure(input bit chg, input logic [3:0] nd, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge CLK);
            if (MOTOR_EN[0] === 1'b1) h0++;
            if (MOTOR_EN[1] === 1'b1) h1++;
            if (chg && m_cnt == 4'd8) DUTY[3:0] = nd;
        end
    endtask

    task automatic dead_seq(input logic [1:0] btn_req, input logic [1:0] sw_req, input bit toggle,
                            input logic dir_before, input logic dir_after, input string tag);
        int da_len = 0;
        BTN = btn_req;
        SW  = sw_req;
        for (int j = 1; j <= 13; j++) begin
            step();
            if (DEAD_ACTIVE[0] === 1'b1) da_len++;
            check({tag, "_da"},  {31'd0, DEAD_ACTIVE[0]}, {31'd0, (j <= 10)});
            check({tag, "_en"},  {31'd0, MOTOR_EN[0]},    {31'd0, (j >= 13)});
            check({tag, "_dir"}, {31'd0, MOTOR_DIR[0]},   {31'd0, (j >= 12) ? dir_after : dir_before});
            if (toggle) begin
                if (j == 3) BTN[0] = 1'b1;
                if (j == 5) BTN[0] = 1'b0;
                if (j == 7) BTN[0] = 1'b1;
            end
        end
        check({tag, "_dead_len"}, da_len, 10);
    endtask

    typedef struct {
        logic [1:0] btn;
        logic [1:0] sw;
        logic [1:0] exp_en;
        logic [1:0] exp_dir;
        logic [1:0] exp_da;
    } io_vec_t;

    typedef struct {
        logic [3:0] duty;
        int         exp_same;
        int         exp_next;
    } pwm_vec_t;

    io_vec_t  io_tab[6];
    pwm_vec_t pwm_tab[4];
    int       ramp_exp[7];

    initial begin
        int h0, h1;

        io_tab[0] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        io_tab[1] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
        io_tab[2] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        io_tab[3] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        io_tab[4] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b00};
        io_tab[5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
`ifdef MOTOR_RAMP_EN
        pwm_tab[0] = '{4'd12, 4, 5};
        pwm_tab[1] = '{4'd0,  6, 0};
        pwm_tab[2] = '{4'd15, 0, 1};
        pwm_tab[3] = '{4'd4,  2, 3};
        ramp_exp   = '{0, 1, 2, 3, 4, 5, 5};
`else
        pwm_tab[0] = '{4'd12, 4,  12};
        pwm_tab[1] = '{4'd0,  12, 0};
        pwm_tab[2] = '{4'd15, 0,  15};
        pwm_tab[3] = '{4'd4,  15, 4};
        ramp_exp   = '{5, 5, 5, 5, 5, 5, 5};
`endif

        // Reset from power-up, then again with both channels running.
        RST = 1'b1; BTN = 2'b00; SW = 2'b00; PWM_EN = 1'b0; DUTY = 8'h00;
        step(); step();
        check("por_en",  {30'd0, MOTOR_EN},    32'd0);
        check("por_dir", {30'd0, MOTOR_DIR},   32'd0);
        check("por_da",  {30'd0, DEAD_ACTIVE}, 32'd0);
        RST = 1'b0; BTN = 2'b11; SW = 2'b11;
        repeat (4) step();
        check("run_before_rst_en", {30'd0, MOTOR_EN}, 32'd3);
        RST = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            check("rst_en",  {30'd0, MOTOR_EN},    32'd0);
            check("rst_dir", {30'd0, MOTOR_DIR},   32'd0);
            check("rst_da",  {30'd0, DEAD_ACTIVE}, 32'd0);
        end
        BTN = 2'b00; SW = 2'b00;
        step();
        RST = 1'b0;
        step();

        // Start/direction vectors with PWM disabled.
        for (int i = 0; i < 6; i++) begin
            BTN = io_tab[i].btn;
            SW  = io_tab[i].sw;
            step();
            check($sformatf("vec%0d_en", i),  {30'd0, MOTOR_EN},    {30'd0, io_tab[i].exp_en});
            check($sformatf("vec%0d_dir", i), {30'd0, MOTOR_DIR},   {30'd0, io_tab[i].exp_dir});
            check($sformatf("vec%0d_da", i),  {30'd0, DEAD_ACTIVE}, {30'd0, io_tab[i].exp_da});
        end

        // PWM duty table: change duty mid-period, expect it only from the next period.
        DUTY = 8'h04; PWM_EN = 1'b1;
        repeat (96) step();
        for (int i = 0; i < 4; i++) begin
            wait_cnt(4'd1);
            measure(1'b1, pwm_tab[i].duty, h0, h1);
            check($sformatf("duty%0d_same_period", i), h0, pwm_tab[i].exp_same);
            check($sformatf("duty%0d_ch1_idle", i), h1, 0);
            wait_cnt(4'd1);
            measure(1'b0, 4'd0, h0, h1);
            check($sformatf("duty%0d_next_period", i), h0, pwm_tab[i].exp_next);
        end

        // Reversal with dead time, then stop with BTN toggling inside DEAD.
        PWM_EN = 1'b0;
        step(); step();
        check("pre_rev_en",  {31'd0, MOTOR_EN[0]},  32'd1);
        check("pre_rev_dir", {31'd0, MOTOR_DIR[0]}, 32'd1);
        dead_seq(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, "rev");
        dead_seq(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, "btn_toggle");

        // Reset in the middle of DEAD aborts it immediately.
        BTN = 2'b00; SW = 2'b10;
        repeat (4) step();
        check("mid_dead_da",  {30'd0, DEAD_ACTIVE}, 32'd1);
        check("mid_dead_dir", {30'd0, MOTOR_DIR},   32'd2);
        RST = 1'b1;
        step();
        check("rst_dead_en",  {30'd0, MOTOR_EN},    32'd0);
        check("rst_dead_dir", {30'd0, MOTOR_DIR},   32'd0);
        check("rst_dead_da",  {30'd0, DEAD_ACTIVE}, 32'd0);
        RST = 1'b0; SW = 2'b00;
        step();
        check("post_rst_da", {30'd0, DEAD_ACTIVE}, 32'd0);

        // Soft-start: press exactly at the period boundary, count highs per period.
        DUTY = 8'h05; PWM_EN = 1'b1;
        repeat (20) step();
        wait_cnt(4'd15);
        BTN = 2'b01;
        for (int p = 0; p < 7; p++) begin
            wait_cnt(4'd1);
            measure(1'b0, 4'd0, h0, h1);
            check($sformatf("ramp_period%0d", p), h0, ramp_exp[p]);
        end

        check("dir_change_while_en", glitches, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
